// File: rtl/mem_pkg.sv
// Shared types and constants for the unified memory sequencer.
// No logic in here: the state encoding, line geometry and the
// requester encoding used by the last-grant flag.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_FILL = 2'd1,
    D_WB   = 2'd2,
    D_FILL = 2'd3
  } state_t;

  localparam int LINE_AW = 14;
  localparam int LINE_DW = 64;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with a synchronous clear.
// Latency: the count updates on the rising edge after i_inc/i_clr.
// No backpressure: it sticks at all-ones, and i_clr wins over i_inc.
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up while i_inc is high, hold at all-ones, clear on request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/umem_arbiter.sv
// Arbitrates the I- and D-cache line misses onto the single-ported unified memory.
// On a dirty D miss it writes back the victim and then refills.
// Latency: the request starts the cycle after the miss is seen in IDLE, and the
// fill write happens in the u_rdy cycle. Misses wait while busy; ties go round-robin.
module umem_arbiter #(
  parameter int LINE_AW = 14,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_miss,
  input  logic [LINE_AW-1:0] i_line_addr,
  input  logic               d_miss,
  input  logic               d_dirty,
  input  logic [LINE_AW-1:0] d_line_addr,
  input  logic [LINE_AW-1:0] d_victim_addr,
  input  logic               u_rdy,
  input  logic               stat_clr,
  output logic               u_re,
  output logic               u_we,
  output logic [LINE_AW-1:0] u_addr,
  output logic               i_we,
  output logic               d_we,
  output logic               d_fill_sel,
  output logic               busy,
  output logic [CNT_W-1:0]   i_stall_cnt,
  output logic [CNT_W-1:0]   d_stall_cnt
);

  import mem_pkg::*;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_last_grant;
  logic   w_grant_vld;
  logic   w_grant_req;

  // State register and last-grant flag. Reset leaves last_grant at D,
  // so the first tie goes to the I-cache.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_grant <= REQ_D;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant_vld) begin
        r_last_grant <= w_grant_req;
      end
    end
  end

  // Arbitration in IDLE and sequencing of the memory transactions.
  // d_dirty only matters in the cycle the D-cache is granted.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_vld = 1'b0;
    w_grant_req = REQ_I;
    case (r_state)
      IDLE: begin
        if (i_miss && d_miss) begin
          w_grant_vld = 1'b1;
          w_grant_req = (r_last_grant == REQ_D) ? REQ_I : REQ_D;
        end else if (i_miss) begin
          w_grant_vld = 1'b1;
          w_grant_req = REQ_I;
        end else if (d_miss) begin
          w_grant_vld = 1'b1;
          w_grant_req = REQ_D;
        end
        if (w_grant_vld) begin
          if (w_grant_req == REQ_I) begin
            w_state_nxt = I_FILL;
          end else begin
            w_state_nxt = d_dirty ? D_WB : D_FILL;
          end
        end
      end
      I_FILL: if (u_rdy) w_state_nxt = IDLE;
      D_WB:   if (u_rdy) w_state_nxt = D_FILL;
      D_FILL: if (u_rdy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output decode. Requests and address are Moore outputs of the state, so they
  // stay stable until u_rdy. Fill enables are Mealy on u_rdy and last one cycle.
  always_comb begin
    u_re       = 1'b0;
    u_we       = 1'b0;
    u_addr     = i_line_addr;
    i_we       = 1'b0;
    d_we       = 1'b0;
    d_fill_sel = 1'b0;
    case (r_state)
      I_FILL: begin
        u_re = 1'b1;
        i_we = u_rdy;
      end
      D_WB: begin
        u_we   = 1'b1;
        u_addr = d_victim_addr;
      end
      D_FILL: begin
        u_re       = 1'b1;
        u_addr     = d_line_addr;
        d_we       = u_rdy;
        d_fill_sel = u_rdy;
      end
      default: ;
    endcase
  end

  assign busy = (r_state != IDLE);

  sat_cnt #(.W(CNT_W)) u_i_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (i_miss),
    .i_clr (stat_clr),
    .o_cnt (i_stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_d_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (d_miss),
    .i_clr (stat_clr),
    .o_cnt (d_stall_cnt)
  );

endmodule

// File: tb/tb_umem_arbiter.sv
// Directed bench for umem_arbiter. The memory model answers each request in its 4th cycle.
// A second instance with 4-bit counters shares the stimulus so that saturation can be checked.
// Outputs are sampled 1 time unit after the rising edge.
module tb_umem_arbiter;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_miss = 1'b0;
  logic [AW-1:0] i_line_addr = '0;
  logic          d_miss = 1'b0;
  logic          d_dirty = 1'b0;
  logic [AW-1:0] d_line_addr = '0;
  logic [AW-1:0] d_victim_addr = '0;
  logic          u_rdy;
  logic          stat_clr = 1'b0;

  logic          u_re, u_we, i_we, d_we, d_fill_sel, busy;
  logic [AW-1:0] u_addr;
  logic [15:0]   i_stall_cnt, d_stall_cnt;

  logic          s_u_re, s_u_we, s_i_we, s_d_we, s_d_fill_sel, s_busy;
  logic [AW-1:0] s_u_addr;
  logic [3:0]    s_i_stall_cnt, s_d_stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  umem_arbiter #(.LINE_AW(AW), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_line_addr(i_line_addr),
    .d_miss(d_miss), .d_dirty(d_dirty), .d_line_addr(d_line_addr),
    .d_victim_addr(d_victim_addr), .u_rdy(u_rdy), .stat_clr(stat_clr),
    .u_re(u_re), .u_we(u_we), .u_addr(u_addr), .i_we(i_we), .d_we(d_we),
    .d_fill_sel(d_fill_sel), .busy(busy),
    .i_stall_cnt(i_stall_cnt), .d_stall_cnt(d_stall_cnt)
  );

  umem_arbiter #(.LINE_AW(AW), .CNT_W(4)) u_dut_c4 (
    .clk(clk), .rst_n(rst_n),
    .i_miss(i_miss), .i_line_addr(i_line_addr),
    .d_miss(d_miss), .d_dirty(d_dirty), .d_line_addr(d_line_addr),
    .d_victim_addr(d_victim_addr), .u_rdy(u_rdy), .stat_clr(stat_clr),
    .u_re(s_u_re), .u_we(s_u_we), .u_addr(s_u_addr), .i_we(s_i_we), .d_we(s_d_we),
    .d_fill_sel(s_d_fill_sel), .busy(s_busy),
    .i_stall_cnt(s_i_stall_cnt), .d_stall_cnt(s_d_stall_cnt)
  );

  // Fixed-latency memory: done in the 4th cycle of each request.
  logic [1:0] m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         m_cnt <= 2'd0;
    else if ((u_re || u_we) && !u_rdy)  m_cnt <= m_cnt + 2'd1;
    else                                m_cnt <= 2'd0;
  end
  assign u_rdy = (u_re || u_we) && (m_cnt == 2'd3);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held with both misses high.
    i_miss = 1'b1; d_miss = 1'b1; i_line_addr = 14'h0777; d_line_addr = 14'h0555;
    tick; tick;
    chk("rst_u_re", 32'(u_re), 32'd0);
    chk("rst_u_we", 32'(u_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_i_we", 32'(i_we), 32'd0);
    chk("rst_d_we", 32'(d_we), 32'd0);
    chk("rst_icnt", 32'(i_stall_cnt), 32'd0);
    chk("rst_dcnt", 32'(d_stall_cnt), 32'd0);
    chk("rst_addr", 32'(u_addr), 32'h0777);
    rst_n = 1'b1;
    tick;
    chk("tie1_u_re", 32'(u_re), 32'd1);
    chk("tie1_addr", 32'(u_addr), 32'h0777);
    chk("tie1_u_we", 32'(u_we), 32'd0);
    // Abandon this fill with a reset.
    rst_n = 1'b0;
    #1;
    chk("rst_async_re", 32'(u_re), 32'd0);
    tick;
    i_miss = 1'b0; d_miss = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    // Clean I miss.
    i_line_addr = 14'h0123; i_miss = 1'b1;
    chk("i_c0_re", 32'(u_re), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick;
      chk("i_re", 32'(u_re), 32'd1);
      chk("i_addr", 32'(u_addr), 32'h0123);
      chk("i_we", 32'(i_we), 32'(c == 4));
    end
    tick;
    i_miss = 1'b0;
    chk("i_busy_end", 32'(busy), 32'd0);
    chk("i_cnt", 32'(i_stall_cnt), 32'd5);

    // Clean D miss.
    d_line_addr = 14'h2A10; d_dirty = 1'b0; d_miss = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      chk("dc_re", 32'(u_re), 32'd1);
      chk("dc_we_mem", 32'(u_we), 32'd0);
      chk("dc_addr", 32'(u_addr), 32'h2A10);
      chk("dc_d_we", 32'(d_we), 32'(c == 4));
      chk("dc_fsel", 32'(d_fill_sel), 32'(c == 4));
    end
    tick;
    d_miss = 1'b0;
    chk("dc_busy_end", 32'(busy), 32'd0);
    chk("dc_cnt", 32'(d_stall_cnt), 32'd5);

    // Dirty D miss: writeback then refill back to back.
    d_victim_addr = 14'h3F05; d_line_addr = 14'h0105; d_dirty = 1'b1; d_miss = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      chk("dd_u_we", 32'(u_we), 32'(c <= 4));
      chk("dd_u_re", 32'(u_re), 32'(c > 4));
      chk("dd_addr", 32'(u_addr), (c <= 4) ? 32'h3F05 : 32'h0105);
      chk("dd_d_we", 32'(d_we), 32'(c == 8));
    end
    tick;
    d_miss = 1'b0; d_dirty = 1'b0;
    chk("dd_busy_end", 32'(busy), 32'd0);
    chk("dd_cnt", 32'(d_stall_cnt), 32'd14);

    // Both held: I, D, I, D with one IDLE cycle between fills.
    i_line_addr = 14'h0111; d_line_addr = 14'h0222; i_miss = 1'b1; d_miss = 1'b1;
    for (int c = 1; c <= 19; c++) begin
      bit idle_c, is_i;
      tick;
      idle_c = (c % 5 == 0);
      is_i   = (((c - 1) / 5) % 2 == 0);
      chk("alt_re", 32'(u_re), 32'(!idle_c));
      chk("alt_addr", 32'(u_addr), (idle_c || is_i) ? 32'h0111 : 32'h0222);
      chk("alt_i_we", 32'(i_we), 32'(c == 4 || c == 14));
      chk("alt_d_we", 32'(d_we), 32'(c == 9 || c == 19));
    end
    tick;
    i_miss = 1'b0; d_miss = 1'b0;
    chk("alt_busy_end", 32'(busy), 32'd0);
    tick;
    chk("alt_stay_idle", 32'(busy), 32'd0);

    // Counter clear and saturation.
    stat_clr = 1'b1;
    tick;
    stat_clr = 1'b0;
    chk("clr_icnt", 32'(i_stall_cnt), 32'd0);
    chk("clr_dcnt", 32'(d_stall_cnt), 32'd0);
    chk("clr_c4_icnt", 32'(s_i_stall_cnt), 32'd0);
    i_line_addr = 14'h0333; i_miss = 1'b1;
    repeat (20) tick;
    chk("sat_c4_icnt", 32'(s_i_stall_cnt), 32'hF);
    chk("sat_icnt", 32'(i_stall_cnt), 32'd20);
    chk("sat_c4_dcnt", 32'(s_d_stall_cnt), 32'd0);
    stat_clr = 1'b1;
    tick;
    stat_clr = 1'b0;
    chk("clrprio_c4", 32'(s_i_stall_cnt), 32'd0);
    chk("clrprio_icnt", 32'(i_stall_cnt), 32'd0);
    tick;
    chk("after_clr_icnt", 32'(i_stall_cnt), 32'd1);
    i_miss = 1'b0;
    for (int k = 0; k < 12 && busy; k++) tick;
    chk("drain_idle", 32'(busy), 32'd0);

    // Reset in the middle of a writeback.
    d_victim_addr = 14'h3F05; d_line_addr = 14'h0105; d_dirty = 1'b1; d_miss = 1'b1;
    tick;
    chk("mid_wb_we", 32'(u_we), 32'd1);
    tick;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 32'(u_we), 32'd0);
    chk("mid_rst_re", 32'(u_re), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    tick;
    chk("mid_rst_dwe", 32'(d_we), 32'd0);
    d_miss = 1'b0; d_dirty = 1'b0;
    rst_n = 1'b1;
    tick;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_we", 32'(u_we), 32'd0);
    chk("post_rst_dwe", 32'(d_we), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/umem_arbiter.md
# umem_arbiter

Sequencer and arbiter for the single-ported unified memory shared by the instruction cache and the data cache. Accepts line-miss requests from both caches and grants memory to one at a time, round-robin on a tie. For a data miss with a dirty victim it runs the writeback, then the refill. It drives the cache fill write-enables and keeps saturating per-requester stall counters for performance analysis.

## Interface
Parameters:
- LINE_AW, 14, line address width (word address [15:2])
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- i_miss  in  1  I-cache miss, held until fill completes
- i_line_addr  in  LINE_AW  I-cache missing line address
- d_miss  in  1  D-cache miss (read or write), held until fill completes
- d_dirty  in  1  D-cache victim line dirty; sampled on D grant
- d_line_addr  in  LINE_AW  D-cache missing line address
- d_victim_addr  in  LINE_AW  victim line address {tag, index}
- u_rdy  in  1  unified memory done; read data valid this cycle
- stat_clr  in  1  synchronous clear of both stall counters
- u_re  out  1  memory read request
- u_we  out  1  memory write request (data from D-cache line)
- u_addr  out  LINE_AW  memory line address
- i_we  out  1  write memory read data into I-cache
- d_we  out  1  write memory read data into D-cache
- d_fill_sel  out  1  D-cache write data = memory read data
- busy  out  1  state != IDLE
- i_stall_cnt  out  CNT_W  cycles with i_miss high
- d_stall_cnt  out  CNT_W  cycles with d_miss high

## Operation
- States: IDLE, I_FILL, D_WB, D_FILL.
- IDLE:
  - only i_miss -> I_FILL
  - only d_miss -> D_WB if d_dirty, else D_FILL
  - both -> grant the requester not served last (last_grant flag); last_grant updates on every grant.
- I_FILL: u_re=1, u_addr=i_line_addr. When u_rdy=1: i_we=1 that cycle, next state IDLE.
- D_WB: u_we=1, u_addr=d_victim_addr. When u_rdy=1, next state D_FILL. There is no idle cycle between the two transactions.
- D_FILL: u_re=1, u_addr=d_line_addr. When u_rdy=1: d_we=1 and d_fill_sel=1 that cycle, next state IDLE. The fill writes the line clean. The store merge for a write miss is performed by the cache's own hit path afterwards.
- Outside these cases, u_re, u_we, i_we, d_we and d_fill_sel are 0, and u_addr = i_line_addr.
- u_rdy outside I_FILL/D_WB/D_FILL is ignored.
- Requesters drop their miss signal in the cycle after their fill write, because the hit is then visible. The arbiter therefore re-arbitrates from IDLE without a guard cycle.
- Stall counters:
  - increment each cycle the respective miss is high
  - saturate at all-ones
  - stat_clr has priority over increment

## Timing
- Reset (asynchronous): state IDLE, last_grant=D (first tie goes to I), both counters 0. All outputs 0 except u_addr = i_line_addr.
- u_re, u_we and u_addr are Moore outputs of state.
  - Miss seen in IDLE at cycle n -> request asserted from cycle n+1.
  - Request is held stable until the u_rdy cycle inclusive.
- i_we, d_we and d_fill_sel are Mealy on u_rdy in the fill state, lasting exactly 1 cycle.
- Clean miss with memory latency L (u_rdy in the L-th request cycle): fill write at cycle n+L, back in IDLE at n+L+1.
- Dirty miss: fill write at cycle n+2L.
- Reset mid-transaction: requests drop immediately and the transaction is abandoned. No fill write is issued.
- A miss that arrives while busy waits in IDLE arbitration. It is never lost because requesters hold it.

## Structure
- Shared package mem_pkg:
  - state enum {IDLE, I_FILL, D_WB, D_FILL}
  - LINE_AW=14
  - LINE_DW=64
  - requester encoding (REQ_I=0, REQ_D=1)
- One sub-module: sat_cnt (width-parameterised saturating counter with inc and clr), instantiated twice.
- FSM, arbitration and output decode live in umem_arbiter.

## Test plan
Memory model: fixed latency L=4.
- Reset: hold rst_n=0 with i_miss=d_miss=1 -> all requests 0, busy=0, counters 0. Release -> u_re=1, u_addr=i_line_addr (I wins the first tie).
- I miss, i_line_addr=0x0123 -> u_re cycles 1..4 at 0x0123, i_we=1 only in cycle 4, busy low in cycle 5, i_stall_cnt=5.
- D clean miss, d_line_addr=0x2A10 -> u_re at 0x2A10 for 4 cycles, d_we=d_fill_sel=1 in the last one, u_we never asserted.
- D dirty miss, victim 0x3F05, line 0x0105 -> u_we at 0x3F05 cycles 1..4, u_re at 0x0105 cycles 5..8, d_we in cycle 8.
- Simultaneous misses held repeatedly -> grants alternate I, D, I, D. Second D starts in the cycle after the I fill returns to IDLE.
- Counter saturation: CNT_W=4, i_miss high 20 cycles -> i_stall_cnt holds 0xF. stat_clr concurrent with miss -> 0 next cycle.
- Assert rst_n=0 mid-D_WB -> u_we drops asynchronously, no d_we, state IDLE after release.
